// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU issue block and its bench.
//   ALU_* : opcodes understood by the combinational alu (LEFT passes left
//           operand through, cond is always out[0]).
//   MUL_OP_DEFAULT : issue opcode that selects the iterated multiply; chosen
//           outside the ALU_* range so it can never alias an ALU operation.
//   state_e : FSM encoding of alu_issue, also visible on its debug port.
package alu_issue_pkg;

  localparam logic [4:0] ALU_LEFT  = 5'h00;
  localparam logic [4:0] ALU_RIGHT = 5'h01;
  localparam logic [4:0] ALU_ADD   = 5'h02;
  localparam logic [4:0] ALU_SUB   = 5'h03;
  localparam logic [4:0] ALU_AND   = 5'h04;
  localparam logic [4:0] ALU_OR    = 5'h05;
  localparam logic [4:0] ALU_XOR   = 5'h06;
  localparam logic [4:0] ALU_EQ    = 5'h07;
  localparam logic [4:0] ALU_NE    = 5'h08;
  localparam logic [4:0] ALU_LT    = 5'h09;

  localparam logic [4:0] MUL_OP_DEFAULT = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_MUL    = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

endpackage

// File: rtl/alu_issue.sv
// alu_issue: initiator for the combinational alu. Takes one tagged request
// at a time from decode, runs it through the alu (one cycle for native ops,
// an add/shift loop for MUL_OP), then offers the tagged result.
//
// Handshakes (both iss__ and res__): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer keeps valid and payload
// stable until that edge; ready may be asserted without valid.
//
// Ports:
//   clk, rst_b                     clock, async active-low reset
//   iss__valid/ready/op/left/right/tag   request from decode
//   alu__op/left/right (out)       operands to the external alu
//   alu__out/alu__cond (in)        alu result, combinational from alu__*
//   res__valid/ready/data/cond/tag result to consumer
//   dbg__state                     current FSM state (state_e encoding)
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter logic [4:0] MUL_OP = MUL_OP_DEFAULT,
  parameter int         TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             iss__valid,
  output logic             iss__ready,
  input  logic [4:0]       iss__op,
  input  logic [31:0]      iss__left,
  input  logic [31:0]      iss__right,
  input  logic [TAG_W-1:0] iss__tag,
  output logic [4:0]       alu__op,
  output logic [31:0]      alu__left,
  output logic [31:0]      alu__right,
  input  logic [31:0]      alu__out,
  input  logic             alu__cond,
  output logic             res__valid,
  input  logic             res__ready,
  output logic [31:0]      res__data,
  output logic             res__cond,
  output logic [TAG_W-1:0] res__tag,
  output logic [1:0]       dbg__state
);

  state_e state_q, state_d;

  // left_q doubles as the multiplicand and right_q as the multiplier while
  // in MUL; both are shifted locally each iteration.
  logic [4:0]       op_q;
  logic [31:0]      left_q;
  logic [31:0]      right_q;
  logic [31:0]      acc_q;
  logic [4:0]       cnt_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      res_data_q;
  logic             res_cond_q;
  logic             mul_done;

  // Last iteration: no multiplier bits remain after this shift, or this is
  // the 32nd pass.
  assign mul_done = (right_q[31:1] == 31'd0) || (cnt_q == 5'd31);

  assign iss__ready = (state_q == ST_IDLE);
  assign res__valid = (state_q == ST_RESULT);
  assign res__data  = res_data_q;
  assign res__cond  = res_cond_q;
  assign res__tag   = tag_q;
  assign dbg__state = state_q;

  // alu__* depend only on state and registers, never on iss__*.
  always_comb begin
    state_d    = state_q;
    alu__op    = ALU_LEFT;
    alu__left  = 32'd0;
    alu__right = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (iss__valid) state_d = (iss__op == MUL_OP) ? ST_MUL : ST_EXEC;
      end
      ST_EXEC: begin
        alu__op    = op_q;
        alu__left  = left_q;
        alu__right = right_q;
        state_d    = ST_RESULT;
      end
      ST_MUL: begin
        // LEFT on a zero multiplier bit just carries acc through unchanged.
        alu__op    = right_q[0] ? ALU_ADD : ALU_LEFT;
        alu__left  = acc_q;
        alu__right = left_q;
        if (mul_done) state_d = ST_RESULT;
      end
      ST_RESULT: begin
        if (res__ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      op_q       <= ALU_LEFT;
      left_q     <= 32'd0;
      right_q    <= 32'd0;
      acc_q      <= 32'd0;
      cnt_q      <= 5'd0;
      tag_q      <= '0;
      res_data_q <= 32'd0;
      res_cond_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (iss__valid) begin
            op_q    <= iss__op;
            left_q  <= iss__left;
            right_q <= iss__right;
            tag_q   <= iss__tag;
            acc_q   <= 32'd0;
            cnt_q   <= 5'd0;
          end
        end
        ST_EXEC: begin
          res_data_q <= alu__out;
          res_cond_q <= alu__cond;
        end
        ST_MUL: begin
          acc_q   <= alu__out;
          left_q  <= left_q << 1;
          right_q <= right_q >> 1;
          cnt_q   <= cnt_q + 5'd1;
          if (mul_done) begin
            res_data_q <= alu__out;
            res_cond_q <= alu__cond;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int TAG_W = 4;
  localparam int PW    = 32 + 1 + TAG_W;

  logic             clk;
  logic             rst_b;
  logic             iss__valid;
  logic             iss__ready;
  logic [4:0]       iss__op;
  logic [31:0]      iss__left;
  logic [31:0]      iss__right;
  logic [TAG_W-1:0] iss__tag;
  logic [4:0]       alu__op;
  logic [31:0]      alu__left;
  logic [31:0]      alu__right;
  logic [31:0]      alu__out;
  logic             alu__cond;
  logic             res__valid;
  logic             res__ready;
  logic [31:0]      res__data;
  logic             res__cond;
  logic [TAG_W-1:0] res__tag;
  logic [1:0]       dbg__state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] exp_q[$];
  logic [31:0]   cur_r;
  logic [4:0]    cur_op;

  alu_issue #(.MUL_OP(MUL_OP_DEFAULT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_b(rst_b),
    .iss__valid(iss__valid), .iss__ready(iss__ready), .iss__op(iss__op),
    .iss__left(iss__left), .iss__right(iss__right), .iss__tag(iss__tag),
    .alu__op(alu__op), .alu__left(alu__left), .alu__right(alu__right),
    .alu__out(alu__out), .alu__cond(alu__cond),
    .res__valid(res__valid), .res__ready(res__ready), .res__data(res__data),
    .res__cond(res__cond), .res__tag(res__tag), .dbg__state(dbg__state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural alu the block talks to
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] l, input logic [31:0] r);
    case (op)
      ALU_LEFT:  return l;
      ALU_RIGHT: return r;
      ALU_ADD:   return l + r;
      ALU_SUB:   return l - r;
      ALU_AND:   return l & r;
      ALU_OR:    return l | r;
      ALU_XOR:   return l ^ r;
      ALU_EQ:    return {31'd0, l == r};
      ALU_NE:    return {31'd0, l != r};
      ALU_LT:    return {31'd0, l < r};
      default:   return 32'h5A5A_0000 | {27'd0, op};
    endcase
  endfunction

  always_comb begin
    alu__out  = alu_fn(alu__op, alu__left, alu__right);
    alu__cond = alu__out[0];
  end

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] l, input logic [31:0] r);
    if (op == MUL_OP_DEFAULT) return l * r;
    return alu_fn(op, l, r);
  endfunction

  function automatic int exp_latency(input logic [4:0] op, input logic [31:0] r);
    int it;
    if (op != MUL_OP_DEFAULT) return 2;
    it = 1;
    for (int b = 0; b < 32; b++) if (r[b]) it = b + 1;
    return 1 + it;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // driver: called just after a negedge; returns #1 after the accept edge
  task automatic issue(input logic [4:0] op, input logic [31:0] l, input logic [31:0] r,
                       input logic [TAG_W-1:0] tag);
    logic [31:0] d;
    int w = 0;
    while (iss__ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("iss_ready_timeout", 64'd0, 64'd1);
    iss__valid = 1'b1;
    iss__op    = op;
    iss__left  = l;
    iss__right = r;
    iss__tag   = tag;
    @(posedge clk);
    #1;
    iss__valid = 1'b0;
    cur_op = op;
    cur_r  = r;
    d = ref_result(op, l, r);
    exp_q.push_back({d, d[0], tag});
  endtask

  // waits for the result, checks latency/busy/mul sequencing, optional
  // backpressure hold, then takes the result. Ends at a negedge.
  task automatic collect(input bit chk_mul, input int hold);
    int k = 0;
    int lat;
    logic [PW-1:0] e;
    logic [PW-1:0] first;
    bit stable = 1'b1;
    lat = exp_latency(cur_op, cur_r);
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (res__valid === 1'b1) break;
      check("iss_ready_busy", {63'd0, iss__ready}, 64'd0);
      if (chk_mul && k <= 32)
        check("mul_alu_op", {59'd0, alu__op}, {59'd0, cur_r[k-1] ? ALU_ADD : ALU_LEFT});
    end
    if (res__valid !== 1'b1) begin
      check("res_timeout", 64'd0, 64'd1);
      return;
    end
    check("latency", 64'(k), 64'(lat));
    check("iss_ready_in_result", {63'd0, iss__ready}, 64'd0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    first = {res__data, res__cond, res__tag};
    check("res_payload", 64'(first), 64'(e));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        if (res__valid !== 1'b1 || iss__ready !== 1'b0 ||
            {res__data, res__cond, res__tag} !== first) stable = 1'b0;
      end
      check("backpressure_stable", {63'd0, stable}, 64'd1);
    end
    res__ready = 1'b1;
    @(posedge clk);
    #1;
    res__ready = 1'b0;
    @(negedge clk);
    check("iss_ready_after_result", {63'd0, iss__ready}, 64'd1);
    check("res_valid_after_result", {63'd0, res__valid}, 64'd0);
  endtask

  initial begin
    logic [4:0] rops[6];
    bit seen;
    rst_b      = 1'b0;
    iss__valid = 1'b0;
    iss__op    = 5'd0;
    iss__left  = 32'd0;
    iss__right = 32'd0;
    iss__tag   = '0;
    res__ready = 1'b0;
    rops = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_LT, MUL_OP_DEFAULT, 5'h15};

    #1;
    check("rst_iss_ready", {63'd0, iss__ready}, 64'd1);
    check("rst_res_valid", {63'd0, res__valid}, 64'd0);
    check("rst_res_payload", 64'({res__data, res__cond, res__tag}), 64'd0);
    check("rst_alu_outputs", {alu__op, alu__left, alu__right}, {ALU_LEFT, 64'd0});
    check("rst_state", {62'd0, dbg__state}, 64'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    issue(ALU_ADD, 32'd5, 32'd7, 4'd3);    collect(1'b0, 0);
    issue(ALU_EQ, 32'd9, 32'd9, 4'd4);     collect(1'b0, 0);
    issue(ALU_NE, 32'd9, 32'd9, 4'd5);     collect(1'b0, 0);
    issue(MUL_OP_DEFAULT, 32'd1234, 32'd5678, 4'd6);             collect(1'b1, 0);
    issue(MUL_OP_DEFAULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7);   collect(1'b1, 0);
    issue(MUL_OP_DEFAULT, 32'hDEAD_BEEF, 32'd0, 4'd8);           collect(1'b1, 0);

    // backpressure, then immediate follow-on request
    issue(ALU_SUB, 32'd100, 32'd1, 4'd9);  collect(1'b0, 10);
    issue(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_4321, 4'd10); collect(1'b0, 0);

    // randomised mix, including an opcode outside the ALU set
    for (int i = 0; i < 8; i++) begin
      logic [4:0] op;
      logic [31:0] r;
      op = rops[$urandom_range(0, 5)];
      r  = (op == MUL_OP_DEFAULT) ? 32'($urandom_range(0, 65535)) : $urandom;
      issue(op, $urandom, r, 4'($urandom_range(0, 15)));
      collect(op == MUL_OP_DEFAULT, $urandom_range(0, 3));
    end

    // reset in the middle of MUL iteration 5
    issue(MUL_OP_DEFAULT, 32'h1234_5678, 32'h0000_FFFF, 4'd11);
    repeat (5) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("midmul_rst_res_valid", {63'd0, res__valid}, 64'd0);
    check("midmul_rst_iss_ready", {63'd0, iss__ready}, 64'd1);
    check("midmul_rst_alu", {alu__op, alu__left, alu__right}, {ALU_LEFT, 64'd0});
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (res__valid !== 1'b0) seen = 1'b1;
    end
    check("no_result_after_reset", {63'd0, seen}, 64'd0);

    issue(ALU_ADD, 32'd1, 32'd1, 4'd12);   collect(1'b0, 0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Initiator side of the combinational `alu` interface. Accepts operation requests from the decode stage over a valid/ready handshake, drives `alu__op/left/right` from registered operands, captures `alu__out`/`alu__cond`, and presents a tagged result over a second valid/ready handshake. Adds one compound operation the ALU lacks: a 32×32→32 multiply, sequenced as iterated ALU adds.

## Interface
- `MUL_OP`, default 5'h1F, issue opcode selecting the multiply sequence; must not collide with any `ALU_*` code in `alu.vh`.
- `TAG_W`, default 4, width of the request tag carried through to the result.
- `clk` in 1: the single clock.
- `rst_b` in 1: reset, asynchronous, active-low.
- `iss__valid` in 1: request present.
- `iss__ready` out 1: block accepts a request this cycle.
- `iss__op` in 5: an `ALU_*` code or `MUL_OP`.
- `iss__left` in 32: left operand / multiplicand.
- `iss__right` in 32: right operand / multiplier.
- `iss__tag` in TAG_W: opaque request tag.
- `alu__op` out 5: opcode to ALU.
- `alu__left` out 32: left operand to ALU.
- `alu__right` out 32: right operand to ALU.
- `alu__out` in 32: ALU result, combinational from the three outputs above.
- `alu__cond` in 1: ALU condition bit (`alu__out[0]`).
- `res__valid` out 1: result present.
- `res__ready` in 1: consumer takes result.
- `res__data` out 32, `res__cond` out 1, `res__tag` out TAG_W: result payload.

## Operation
- FSM states: IDLE, EXEC, MUL, RESULT. Reset state IDLE.
- `iss__ready` = (state == IDLE). Transfer on `iss__valid & iss__ready`; latch op, left, right, tag.
- IDLE → EXEC on transfer with op ≠ MUL_OP. IDLE → MUL on transfer with op = MUL_OP: acc ← 0, mcand ← left, mplr ← right, cnt ← 0.
- EXEC (1 cycle): ALU driven with latched op/left/right; capture `alu__out`, `alu__cond` into result regs; → RESULT.
- MUL (per cycle): if `mplr[0]`, drive `ALU_ADD`, left = acc, right = mcand; else drive `ALU_LEFT`, left = acc, right = mcand. acc ← `alu__out`; mcand ← mcand << 1; mplr ← mplr >> 1; cnt ← cnt + 1. Shifts are local, not through the ALU. Leave MUL when the updated mplr == 0 or cnt reaches 31 (32nd iteration); on that cycle capture `alu__out`/`alu__cond` as result and go → RESULT.
- Multiply iterations = max(1, index of highest set bit of right + 1); right = 0 takes 1 iteration, result 0. Product is the low 32 bits, modulo 2^32; signedness irrelevant.
- RESULT: `res__valid` = 1; payload held stable until `res__ready`; on `res__ready` → IDLE.
- IDLE: ALU driven with `ALU_LEFT`, zero operands (never X).
- Opcodes outside `alu.vh` and ≠ MUL_OP are passed through unchecked; result is whatever the ALU returns.
- `rst_b` low at any time, including mid-MUL or while RESULT is stalled: immediate return to IDLE, request dropped, no result produced.

## Timing
- Reset values: `iss__ready` 1 (IDLE), `res__valid` 0, `res__data` 0, `res__cond` 0, `res__tag` 0, `alu__op` `ALU_LEFT`, `alu__left`/`alu__right` 0.
- Non-MUL latency: accept at cycle N, EXEC at N+1, `res__valid` high at N+2.
- MUL latency: accept at N, `res__valid` high at N+1+iterations (N+2 minimum, N+33 maximum).
- Earliest next accept: cycle after the result transfer. Throughput for back-to-back non-MUL ops: one per 3 cycles with `res__ready` held high.
- All outputs registered except `alu__*`, which are decoded from state and registers only, with no path from `iss__*`.

## Structure
- `MUL_OP` default and the FSM state encodings go in `alu.vh` beside the `ALU_*` opcodes, so decode and the bench share them.
- Single module. The `alu` instance lives in the parent and is wired to the `alu__*` ports. No sub-module is warranted.

## Test plan
- ADD: left 5, right 7, tag 3, accept at N → `res__valid` at N+2; data 12, cond 0, tag 3; `iss__ready` low N+1..N+2.
- EQ: left 9, right 9 → data 1, cond 1. NE on the same operands → data 0, cond 0.
- MUL: 1234 × 5678 → data 7006652, cond 0; 13 iterations; `res__valid` at N+14. Check `alu__op` alternates ADD/LEFT per multiplier bits.
- MUL: 0xFFFFFFFF × 0xFFFFFFFF → data 1, cond 1, 32 iterations. MUL x × 0 → data 0, `res__valid` at N+2.
- Backpressure: hold `res__ready` low 10 cycles in RESULT → payload stable, `iss__ready` low; raise it → transfer, `iss__ready` high the next cycle, new request accepted.
- Reset: drop `rst_b` during MUL iteration 5 → `res__valid` 0, `iss__ready` 1, ALU outputs at reset values immediately, with no result ever emitted. After release, ADD 1+1 → data 2 normally.
